maze_navigate: RTL

Command responder for the maze solver: accepts the solver's heading and forward-move requests, sequences the drivetrain, and returns `mv_cmplt`. It sits between the solver and the PID/motor datapath. For a heading request it holds forward speed at zero until the PID reports the heading is reached. For a move request it ramps forward speed, watches for the requested side opening or a front obstruction, and decelerates to a stop.

---
 rtl/nav_pkg.sv | 16 +
 rtl/opn_edge_det.sv | 47 ++++
 rtl/maze_navigate.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/nav_pkg.sv
// Shared definitions for the maze navigation command responder.
//   SPD_W       : width of the forward speed bus sent to the PID.
//   nav_state_t : command sequencer states.
package nav_pkg;

   localparam int SPD_W = 11;

   typedef enum logic [2:0] {
      IDLE,
      HEADING,
      RAMP_UP,
      DEC_GAP,
      DEC_FAST
   } nav_state_t;

endpackage

// File: rtl/opn_edge_det.sv
// Opening edge detector for the maze navigator.
// Registers the left/right opening inputs and reports a rising edge on a
// side only while the solver has asked to stop at that side.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   lft_opn_i, rght_opn_i  : raw opening indications
//   stp_lft_i, stp_rght_i  : solver stop-at-side requests
//   lft_gap_o, rght_gap_o  : qualified rising-edge pulses (combinational)
module opn_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic lft_opn_i,
   input  logic rght_opn_i,
   input  logic stp_lft_i,
   input  logic stp_rght_i,
   output logic lft_gap_o,
   output logic rght_gap_o
);

   logic [1:0] opn;
   logic [1:0] stp;
   logic [1:0] opn_q;
   logic [1:0] rise;

   // Bit 0 is the left channel, bit 1 the right channel.
   assign opn = {rght_opn_i, lft_opn_i};
   assign stp = {stp_rght_i, stp_lft_i};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         opn_q <= '0;
      end else begin
         opn_q <= opn;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         assign rise[gi] = opn[gi] & ~opn_q[gi] & stp[gi];
      end
   endgenerate

   assign lft_gap_o  = rise[0];
   assign rght_gap_o = rise[1];

endmodule

// File: rtl/maze_navigate.sv
// Maze navigation command responder.
// Accepts heading and forward-move requests from the solver, sequences the
// forward speed (ramp, hold, decelerate) and pulses mv_cmplt when done.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   strt_hdng, strt_mv  : one-cycle command pulses (accepted only in IDLE)
//   stp_lft, stp_rght   : stop the move at a left / right opening
//   mv_cmplt            : one-cycle completion pulse
//   hdng_rdy            : gyro sample strobe, paces every speed update
//   at_hdng             : heading error within tolerance
//   lft_opn, rght_opn   : side openings
//   frwrd_opn           : path ahead clear
//   frwrd_spd           : forward speed to the PID
//   moving              : a command is active
//   en_fusion           : speed above half of MAX_SPD
module maze_navigate
   import nav_pkg::*;
#(
   parameter logic [SPD_W-1:0] SPD_INC = 11'h018,
   parameter logic [SPD_W-1:0] MAX_SPD = 11'h2A0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             strt_hdng,
   input  logic             strt_mv,
   input  logic             stp_lft,
   input  logic             stp_rght,
   output logic             mv_cmplt,
   input  logic             hdng_rdy,
   input  logic             at_hdng,
   input  logic             lft_opn,
   input  logic             rght_opn,
   input  logic             frwrd_opn,
   output logic [SPD_W-1:0] frwrd_spd,
   output logic             moving,
   output logic             en_fusion
);

   // One extra bit of headroom so saturation and underflow are visible.
   localparam logic [SPD_W:0] INC_X    = {1'b0, SPD_INC};
   localparam logic [SPD_W:0] MAX_X    = {1'b0, MAX_SPD};
   localparam logic [SPD_W:0] GAP_DEC  = INC_X << 1;
   localparam logic [SPD_W:0] FAST_DEC = INC_X << 2;

   nav_state_t       state_q, state_d;
   logic [SPD_W-1:0] spd_q, spd_d;
   logic             mv_cmplt_q, mv_cmplt_d;
   logic             moving_q, moving_d;
   logic             en_fusion_q, en_fusion_d;

   logic             lft_gap, rght_gap;
   logic [SPD_W:0]   spd_ext;
   logic [SPD_W:0]   ramp_sum;
   logic [SPD_W:0]   dec_amt;
   logic [SPD_W:0]   dec_diff;
   logic             dec_to_zero;

   opn_edge_det u_opn_edge_det (
      .clk        (clk),
      .rst_n      (rst_n),
      .lft_opn_i  (lft_opn),
      .rght_opn_i (rght_opn),
      .stp_lft_i  (stp_lft),
      .stp_rght_i (stp_rght),
      .lft_gap_o  (lft_gap),
      .rght_gap_o (rght_gap)
   );

   assign spd_ext  = {1'b0, spd_q};
   assign ramp_sum = spd_ext + INC_X;
   assign dec_amt  = (state_q == DEC_FAST) ? FAST_DEC : GAP_DEC;
   assign dec_diff = spd_ext - dec_amt;
   // Borrow out of the top bit or an exact zero both mean "stop now".
   assign dec_to_zero = dec_diff[SPD_W] | (dec_diff == '0);

   always_comb begin
      state_d    = state_q;
      spd_d      = spd_q;
      mv_cmplt_d = 1'b0;

      case (state_q)
         IDLE: begin
            spd_d = '0;
            if (strt_hdng) begin
               state_d = HEADING;
            end else if (strt_mv) begin
               state_d = RAMP_UP;
            end
         end

         HEADING: begin
            spd_d = '0;
            if (hdng_rdy && at_hdng) begin
               mv_cmplt_d = 1'b1;
               state_d    = IDLE;
            end
         end

         RAMP_UP: begin
            if (hdng_rdy) begin
               spd_d = (ramp_sum > MAX_X) ? MAX_SPD : ramp_sum[SPD_W-1:0];
            end
            // Exits are watched every cycle; an obstruction beats a gap.
            if (!frwrd_opn) begin
               state_d = DEC_FAST;
            end else if (lft_gap || rght_gap) begin
               state_d = DEC_GAP;
            end
         end

         DEC_GAP, DEC_FAST: begin
            if ((state_q == DEC_GAP) && !frwrd_opn) begin
               state_d = DEC_FAST;
            end
            if (hdng_rdy) begin
               if (dec_to_zero) begin
                  spd_d      = '0;
                  mv_cmplt_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  spd_d = dec_diff[SPD_W-1:0];
               end
            end
         end

         default: begin
            state_d = IDLE;
            spd_d   = '0;
         end
      endcase

      moving_d    = (state_d != IDLE);
      en_fusion_d = (spd_d > (MAX_SPD >> 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         spd_q       <= '0;
         mv_cmplt_q  <= 1'b0;
         moving_q    <= 1'b0;
         en_fusion_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         spd_q       <= spd_d;
         mv_cmplt_q  <= mv_cmplt_d;
         moving_q    <= moving_d;
         en_fusion_q <= en_fusion_d;
      end
   end

   assign frwrd_spd = spd_q;
   assign mv_cmplt  = mv_cmplt_q;
   assign moving    = moving_q;
   assign en_fusion = en_fusion_q;

endmodule
